// File: rtl/dmem_ctrl_if.sv
// Request/response payload types and the core-facing bundle of the data-memory controller.
// The core drives the request side through master; the controller uses slave.
package dmem_ctrl_pkg;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

endpackage

interface dmem_ctrl_if;
    import dmem_ctrl_pkg::*;

    mem_in_s     from_core_i;
    logic [31:0] addr_i;
    mem_out_s    to_core_o;
    logic        error_o;

    modport master (
        output from_core_i,
        output addr_i,
        input  to_core_o,
        input  error_o
    );

    modport slave (
        input  from_core_i,
        input  addr_i,
        output to_core_o,
        output error_o
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Single-outstanding load/store controller for a local word-organised SRAM.
// Accepts in IDLE, waits latency_p cycles, performs the access, holds the response until acknowledged.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned addr_width_p = 10,
    parameter int unsigned latency_p    = 1
) (
    input  logic        clk,
    input  logic        n_reset,
    dmem_ctrl_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << addr_width_p;
    localparam int unsigned CNT_W = (latency_p > 1) ? $clog2(latency_p + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_addr;
    logic               r_wen;
    logic               r_bnw;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_valid;
    logic               r_error;
    logic [31:0]        r_mem [DEPTH];

    logic                    w_yumi;
    logic                    w_fire;
    logic [31:0]             w_addr;
    logic                    w_wen;
    logic                    w_bnw;
    logic [31:0]             w_wdata;
    logic                    w_fault;
    logic [addr_width_p-1:0] w_idx;
    logic [4:0]              w_shamt;
    logic [31:0]             w_rword;
    logic [31:0]             w_rshift;
    logic [31:0]             w_bmask;
    logic [31:0]             w_wval;
    logic [31:0]             w_rdata;

    assign w_yumi = n_reset && (r_state == IDLE) && bus.from_core_i.valid;

    // With zero latency the access uses the request as it is accepted; otherwise the registered copy.
    assign w_fire  = (latency_p == 0) ? w_yumi : ((r_state == BUSY) && (r_cnt == CNT_W'(1)));
    assign w_addr  = (latency_p == 0) ? bus.addr_i                  : r_addr;
    assign w_wen   = (latency_p == 0) ? bus.from_core_i.wen           : r_wen;
    assign w_bnw   = (latency_p == 0) ? bus.from_core_i.byte_not_word : r_bnw;
    assign w_wdata = (latency_p == 0) ? bus.from_core_i.write_data    : r_wdata;

    assign w_fault  = (|w_addr[31:addr_width_p+2]) || (!w_bnw && (w_addr[1:0] != 2'b00));
    assign w_idx    = w_addr[addr_width_p+1:2];
    assign w_shamt  = {w_addr[1:0], 3'b000};
    assign w_rword  = r_mem[w_idx];
    assign w_rshift = w_rword >> w_shamt;
    assign w_bmask  = 32'h0000_00FF << w_shamt;
    assign w_wval   = w_bnw ? ((w_rword & ~w_bmask) | ({4{w_wdata[7:0]}} & w_bmask)) : w_wdata;
    assign w_rdata  = (w_fault || w_wen) ? 32'h0 :
                      (w_bnw ? {24'h0, w_rshift[7:0]} : w_rword);

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (n_reset && w_fire && w_wen && !w_fault) begin
            r_mem[w_idx] <= w_wval;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_bnw   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (w_fire) begin
                r_state <= RESP;
                r_valid <= 1'b1;
                r_error <= w_fault;
                r_rdata <= w_rdata;
            end
            case (r_state)
                IDLE: begin
                    if (w_yumi) begin
                        r_addr  <= bus.addr_i;
                        r_wen   <= bus.from_core_i.wen;
                        r_bnw   <= bus.from_core_i.byte_not_word;
                        r_wdata <= bus.from_core_i.write_data;
                        if (latency_p != 0) begin
                            r_state <= BUSY;
                            r_cnt   <= CNT_W'(latency_p);
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                RESP: begin
                    if (bus.from_core_i.yumi) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_error <= 1'b0;
                        r_rdata <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.to_core_o = '{read_data: r_rdata, valid: r_valid, yumi: w_yumi};
    assign bus.error_o   = r_error;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (latency 1, 0, 3) driven by directed tables,
// hand-written handshake/reset sequences and randomized traffic against a byte-level memory model.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int unsigned NDUT = 3;
    localparam int unsigned AW   = 10;

    logic        clk = 1'b0;
    mem_in_s     fc   [NDUT];
    logic [31:0] ad   [NDUT];
    mem_out_s    tc   [NDUT];
    logic        er   [NDUT];
    logic        rstn [NDUT];

    int lat_of [NDUT] = '{1, 0, 3};

    int checks = 0;
    int errors = 0;

    // Model memory: bytes 0..63 of each instance, used by the randomized phase.
    logic [7:0] mb [NDUT][64];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        dmem_ctrl_if bus ();
        assign bus.from_core_i = fc[g];
        assign bus.addr_i      = ad[g];
        assign tc[g]           = bus.to_core_o;
        assign er[g]           = bus.error_o;
        dmem_ctrl #(.addr_width_p(AW), .latency_p(LAT)) u_dut (
            .clk     (clk),
            .n_reset (rstn[g]),
            .bus     (bus)
        );
    end

    typedef struct {
        logic        wen;
        logic        bnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete transaction; checks acceptance, latency, response values, stability and release.
    task automatic access(input int s, input logic wen, input logic bnw, input logic [31:0] a,
                          input logic [31:0] wd, input int hold,
                          input logic [31:0] exp_rd, input logic exp_err);
        int n;
        int lat;
        @(negedge clk);
        fc[s].valid = 1'b1;
        fc[s].wen = wen;
        fc[s].byte_not_word = bnw;
        fc[s].write_data = wd;
        ad[s] = a;
        #1;
        n = 0;
        while (!tc[s].yumi && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", 32'(tc[s].yumi), 32'd1);
        @(negedge clk);
        fc[s].valid = 1'b0;
        fc[s].write_data = $urandom();
        ad[s] = $urandom();
        #1;
        lat = 1;
        while (!tc[s].valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(lat_of[s] + 1));
        chk("read_data", tc[s].read_data, exp_rd);
        chk("error", 32'(er[s]), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", 32'(tc[s].valid), 32'd1);
            chk("hold_data", tc[s].read_data, exp_rd);
            chk("hold_error", 32'(er[s]), 32'(exp_err));
        end
        fc[s].yumi = 1'b1;
        @(negedge clk);
        fc[s].yumi = 1'b0;
        #1;
        chk("valid_drop", 32'(tc[s].valid), 32'd0);
    endtask

    // Reference behaviour from the access rules, on a byte-addressed memory.
    task automatic model(input int s, input logic wen, input logic bnw, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int base;
        rd = 32'h0;
        e  = 1'b0;
        if (a >= (32'd1 << (AW + 2)) || (!bnw && (a % 4) != 0)) begin
            e = 1'b1;
        end else begin
            base = int'(a);
            if (bnw) begin
                if (wen) mb[s][base] = wd[7:0];
                else     rd = {24'h0, mb[s][base]};
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (wen) mb[s][base + k] = wd[8*k +: 8];
                    else     rd[8*k +: 8] = mb[s][base + k];
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] erd;
        logic        eerr;
        logic        wen;
        logic        bnw;
        logic [31:0] a;
        logic [31:0] wd;

        tbl[0]  = '{1'b1, 1'b0, 32'h10,       32'hDEADBEEF, 0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h10,       32'h0,        1, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h10,       32'h11223344, 0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 1'b1, 32'h13,       32'h123456A5, 2, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h10,       32'h0,        0, 32'hA5223344, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h13,       32'h0,        0, 32'h000000A5, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'h12,       32'h0,        3, 32'h00000022, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h10,       32'h0,        0, 32'h00000044, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,        32'h55AA55AA, 0, 32'h0,        1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h6,        32'h0,        2, 32'h0,        1'b1};
        tbl[10] = '{1'b1, 1'b0, 32'h1000,     32'hFFFFFFFF, 1, 32'h0,        1'b1};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        32'h0,        0, 32'h55AA55AA, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'h4,        32'h01020304, 0, 32'h0,        1'b0};
        tbl[13] = '{1'b0, 1'b1, 32'h6,        32'h0,        0, 32'h00000002, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 32'h1001,     32'h00000077, 0, 32'h0,        1'b1};
        tbl[15] = '{1'b0, 1'b0, 32'h80000004, 32'h0,        0, 32'h0,        1'b1};
        tbl[16] = '{1'b1, 1'b0, 32'h7,        32'hCAFEF00D, 0, 32'h0,        1'b1};
        tbl[17] = '{1'b0, 1'b0, 32'h4,        32'h0,        0, 32'h01020304, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 32'hFFC,      32'h0BADCAFE, 0, 32'h0,        1'b0};
        tbl[19] = '{1'b0, 1'b1, 32'hFFF,      32'h0,        1, 32'h0000000B, 1'b0};

        for (int s = 0; s < NDUT; s++) begin
            fc[s] = '0;
            ad[s] = '0;
            rstn[s] = 1'b0;
        end

        // Reset values, with a request pending to show yumi is suppressed.
        repeat (2) @(negedge clk);
        for (int s = 0; s < NDUT; s++) fc[s].valid = 1'b1;
        #1;
        for (int s = 0; s < NDUT; s++) begin
            chk("rst_valid", 32'(tc[s].valid), 32'd0);
            chk("rst_rdata", tc[s].read_data, 32'h0);
            chk("rst_error", 32'(er[s]), 32'd0);
            chk("rst_yumi", 32'(tc[s].yumi), 32'd0);
        end
        @(negedge clk);
        for (int s = 0; s < NDUT; s++) begin
            fc[s].valid = 1'b0;
            rstn[s] = 1'b1;
        end
        repeat (5) begin
            @(negedge clk);
            #1;
            for (int s = 0; s < NDUT; s++) begin
                chk("idle_valid", 32'(tc[s].valid), 32'd0);
                chk("idle_yumi", 32'(tc[s].yumi), 32'd0);
                chk("idle_error", 32'(er[s]), 32'd0);
            end
        end

        // Directed vectors on every latency.
        for (int s = 0; s < NDUT; s++) begin
            for (int i = 0; i < 20; i++) begin
                access(s, tbl[i].wen, tbl[i].bnw, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
                       tbl[i].exp_rd, tbl[i].exp_err);
            end
        end

        // Back-pressure: response held 4 cycles without yumi, competing request waits.
        @(negedge clk);
        fc[0].valid = 1'b1;
        fc[0].wen = 1'b0;
        fc[0].byte_not_word = 1'b0;
        ad[0] = 32'h10;
        #1;
        chk("bp_accept", 32'(tc[0].yumi), 32'd1);
        @(negedge clk);
        fc[0].valid = 1'b0;
        ad[0] = $urandom();
        #1;
        n = 0;
        while (!tc[0].valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bp_valid", 32'(tc[0].valid), 32'd1);
        chk("bp_data", tc[0].read_data, 32'hA5223344);
        fc[0].valid = 1'b1;
        ad[0] = 32'h0;
        #1;
        chk("bp_no_accept", 32'(tc[0].yumi), 32'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("bp_hold_valid", 32'(tc[0].valid), 32'd1);
            chk("bp_hold_data", tc[0].read_data, 32'hA5223344);
            chk("bp_no_accept", 32'(tc[0].yumi), 32'd0);
        end
        @(negedge clk);
        fc[0].yumi = 1'b1;
        #1;
        chk("bp_last_valid", 32'(tc[0].valid), 32'd1);
        chk("bp_no_accept", 32'(tc[0].yumi), 32'd0);
        @(negedge clk);
        fc[0].yumi = 1'b0;
        #1;
        chk("bp_valid_drop", 32'(tc[0].valid), 32'd0);
        chk("bp_accept_next", 32'(tc[0].yumi), 32'd1);
        @(negedge clk);
        fc[0].valid = 1'b0;
        #1;
        n = 0;
        while (!tc[0].valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bp_second_data", tc[0].read_data, 32'h55AA55AA);
        fc[0].yumi = 1'b1;
        @(negedge clk);
        fc[0].yumi = 1'b0;

        // Reset while a load is in BUSY, then normal service.
        for (int s = 0; s < NDUT; s += 2) begin
            @(negedge clk);
            fc[s].valid = 1'b1;
            fc[s].wen = 1'b0;
            fc[s].byte_not_word = 1'b0;
            ad[s] = 32'h10;
            #1;
            chk("mrst_accept", 32'(tc[s].yumi), 32'd1);
            @(negedge clk);
            fc[s].valid = 1'b0;
            rstn[s] = 1'b0;
            @(negedge clk);
            fc[s].valid = 1'b1;
            #1;
            chk("mrst_valid", 32'(tc[s].valid), 32'd0);
            chk("mrst_yumi", 32'(tc[s].yumi), 32'd0);
            @(negedge clk);
            fc[s].valid = 1'b0;
            rstn[s] = 1'b1;
            repeat (lat_of[s] + 3) begin
                @(negedge clk);
                #1;
                chk("mrst_idle_valid", 32'(tc[s].valid), 32'd0);
            end
            access(s, 1'b0, 1'b0, 32'h10, 32'h0, 0, 32'hA5223344, 1'b0);
        end

        // Randomized traffic against the byte model: initialise words 0..15, then mixed ops.
        for (int s = 0; s < NDUT; s++) begin
            for (int w = 0; w < 16; w++) begin
                wd = $urandom();
                model(s, 1'b1, 1'b0, 32'(w * 4), wd, erd, eerr);
                access(s, 1'b1, 1'b0, 32'(w * 4), wd, 0, erd, eerr);
            end
            for (int i = 0; i < 60; i++) begin
                wen = 1'($urandom_range(0, 1));
                bnw = 1'($urandom_range(0, 1));
                wd  = $urandom();
                if ($urandom_range(0, 7) == 0) begin
                    a = $urandom() | 32'h1000;
                end else begin
                    a = $urandom_range(0, 63);
                    if (!bnw && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                end
                model(s, wen, bnw, a, wd, erd, eerr);
                access(s, wen, bnw, a, wd, int'($urandom_range(0, 2)), erd, eerr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
